// File: rtl/alu_seq_pkg.sv
// Shared types for the registered NanoMIPS ALU: opcode and state enums plus
// a helper that tells the sequencer which opcodes take more than one cycle.
package alu_seq_pkg;

   typedef enum logic [4:0] {
      OP_PASS0   = 5'h00,
      OP_PASS1   = 5'h01,
      OP_SHL1_0  = 5'h02,
      OP_SHL1_1  = 5'h03,
      OP_SHR1_0  = 5'h04,
      OP_SHR1_1  = 5'h05,
      OP_AND0    = 5'h06,
      OP_AND1    = 5'h07,
      OP_OR0     = 5'h08,
      OP_OR1     = 5'h09,
      OP_XOR     = 5'h0A,
      OP_ORRED   = 5'h0B,
      OP_XORRED  = 5'h0C,
      OP_SUB     = 5'h0D,
      OP_ADD0    = 5'h0E,
      OP_ADD1    = 5'h0F,
      OP_MUL     = 5'h10,
      OP_SHL     = 5'h11,
      OP_SHR     = 5'h12,
      OP_ROL     = 5'h13
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_t;

   // Only the multiply is sequenced; everything else completes on the accept edge.
   function automatic logic is_multicycle(alu_op_t op);
      return op == OP_MUL;
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between register-read (master) and the ALU (slave).
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       alu_opcode;
   logic [WIDTH-1:0] input0;
   logic [WIDTH-1:0] input1;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             err;

   modport master (
      output in_valid, alu_opcode, input0, input1, out_ready,
      input  in_ready, out_valid, result, zero, carry, err
   );

   modport slave (
      input  in_valid, alu_opcode, input0, input1, out_ready,
      output in_ready, out_valid, result, zero, carry, err
   );
endinterface

// File: rtl/alu_seq_mul_iter.sv
// Iterative LSB-first shift-add multiplier. One partial product per step;
// 'product' is the accumulator value the current step would write, so the
// caller can capture the final product on the same edge that 'done' is high.
module alu_mul_iter #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               start,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;

   assign product = mplier[0] ? acc + mcand : acc;
   assign done    = step && (count == CW'(WIDTH - 1));

   // Load operands on start, then add-and-shift once per step.
   always_ff @(posedge clk) begin
      // NOTE: the datapath registers are reset too; this block is tiny and a
      // known post-reset value keeps the held result deterministic.
      if (!rst_n) begin
         count  <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (start) begin
         // NOTE: non-blocking assignments so every register sees the pre-edge
         // values of the others, as real flops do.
         count  <= '0;
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
      end else if (step) begin
         count  <= count + 1'b1;
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes. Single-cycle ops register their
// result on the accept edge; MUL runs WIDTH steps on the iterative multiplier.
// WIDTH must be a power of two and at least 4.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   alu_seq_if.slave   bus
);
   localparam int SHW = $clog2(WIDTH);

   alu_state_t         state;
   alu_op_t            op_in;
   logic               accept;
   logic               mul_start;
   logic               mul_step;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;

   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [SHW-1:0]     shamt;
   logic [WIDTH:0]     sum_ext;
   logic [2*WIDTH-1:0] rol_ext;

   logic [WIDTH-1:0]   sc_result;
   logic               sc_carry;
   logic               sc_err;

   logic [WIDTH-1:0]   result_q;
   logic               out_valid_q;
   logic               zero_q;
   logic               carry_q;
   logic               err_q;

   assign op_in   = alu_op_t'(bus.alu_opcode);
   assign a       = bus.input0;
   assign b       = bus.input1;
   assign shamt   = b[SHW-1:0];
   assign sum_ext = {1'b0, a} + {1'b0, b};
   assign rol_ext = {a, a} << shamt;

   // A finished result can be replaced on the same edge it is consumed.
   assign bus.in_ready = !flush && (state == IDLE || (state == DONE && bus.out_ready));
   assign accept       = bus.in_valid && bus.in_ready;
   assign mul_start    = accept && is_multicycle(op_in);
   assign mul_step     = (state == BUSY) && !flush;

   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.carry     = carry_q;
   assign bus.err       = err_q;

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (flush),
      .start   (mul_start),
      .step    (mul_step),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );

   // Single-cycle result and flags from the live operands.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a variable
      // unassigned, which would infer a latch.
      sc_result = '0;
      sc_carry  = 1'b0;
      sc_err    = 1'b0;
      case (op_in)
         OP_PASS0:          sc_result = a;
         OP_PASS1:          sc_result = b;
         OP_SHL1_0: begin
            sc_result = a << 1;
            sc_carry  = a[WIDTH-1];
         end
         OP_SHL1_1: begin
            sc_result = b << 1;
            sc_carry  = b[WIDTH-1];
         end
         OP_SHR1_0: begin
            sc_result = a >> 1;
            sc_carry  = a[0];
         end
         OP_SHR1_1: begin
            sc_result = b >> 1;
            sc_carry  = b[0];
         end
         OP_AND0, OP_AND1:  sc_result = a & b;
         OP_OR0, OP_OR1:    sc_result = a | b;
         OP_XOR:            sc_result = a ^ b;
         OP_ORRED:          sc_result = {{(WIDTH-1){1'b0}}, |a};
         OP_XORRED:         sc_result = {{(WIDTH-1){1'b0}}, ^a};
         OP_SUB: begin
            sc_result = b - a;
            sc_carry  = b < a;
         end
         OP_ADD0, OP_ADD1: begin
            sc_result = sum_ext[WIDTH-1:0];
            sc_carry  = sum_ext[WIDTH];
         end
         OP_MUL:            sc_result = '0;
         OP_SHL:            sc_result = a << shamt;
         OP_SHR:            sc_result = a >> shamt;
         OP_ROL:            sc_result = rol_ext[2*WIDTH-1:WIDTH];
         default:           sc_err    = 1'b1;
      endcase
   end

   // Sequencer: accept, multiply wait, result hold; flush drops to IDLE but
   // leaves the last result and flags visible.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         err_q       <= 1'b0;
      end else if (flush) begin
         state       <= IDLE;
         out_valid_q <= 1'b0;
      end else if (accept) begin
         if (is_multicycle(op_in)) begin
            state       <= BUSY;
            out_valid_q <= 1'b0;
         end else begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= sc_result;
            zero_q      <= (sc_result == '0);
            carry_q     <= sc_carry;
            err_q       <= sc_err;
         end
      end else begin
         case (state)
            BUSY: begin
               if (mul_done) begin
                  state       <= DONE;
                  out_valid_q <= 1'b1;
                  result_q    <= mul_product[WIDTH-1:0];
                  zero_q      <= (mul_product[WIDTH-1:0] == '0);
                  carry_q     <= |mul_product[2*WIDTH-1:WIDTH];
                  err_q       <= 1'b0;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8. Inputs change and outputs are sampled
// 1 ns after the rising edge.
module tb_alu_seq;
   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   int   n_tests = 0;
   int   n_fail  = 0;

   alu_seq_if #(.WIDTH(8)) bus ();

   alu_seq #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] op, input logic [7:0] x, input logic [7:0] y);
      bus.in_valid   = 1'b1;
      bus.alu_opcode = op;
      bus.input0     = x;
      bus.input1     = y;
   endtask

   // Issue one single-cycle op from IDLE, check it, return to IDLE.
   task automatic run_op(input string tag, input logic [4:0] op, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] exp_res, input logic exp_c);
      drive(op, x, y);
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ".result"}, 32'(bus.result), 32'(exp_res));
      check({tag, ".carry"}, 32'(bus.carry), 32'(exp_c));
      check({tag, ".zero"}, 32'(bus.zero), 32'(exp_res == 8'h00));
      tick();
   endtask

   initial begin
      rst_n          = 1'b0;
      flush          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.alu_opcode = 5'h00;
      bus.input0     = 8'h00;
      bus.input1     = 8'h00;
      bus.out_ready  = 1'b1;
      tick();
      tick();
      check("rst.valid", 32'(bus.out_valid), 32'd0);
      check("rst.result", 32'(bus.result), 32'd0);
      check("rst.zero", 32'(bus.zero), 32'd0);
      check("rst.carry", 32'(bus.carry), 32'd0);
      check("rst.err", 32'(bus.err), 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst.in_ready", 32'(bus.in_ready), 32'd1);

      // ADD with carry-out, latency 1
      drive(5'h0E, 8'hF0, 8'h20);
      #1;
      check("add.in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      check("add.valid", 32'(bus.out_valid), 32'd1);
      check("add.result", 32'(bus.result), 32'h10);
      check("add.carry", 32'(bus.carry), 32'd1);
      check("add.zero", 32'(bus.zero), 32'd0);
      check("add.err", 32'(bus.err), 32'd0);
      tick();
      check("add.drain", 32'(bus.out_valid), 32'd0);

      // SUB equal operands, then a back-to-back SUB with borrow
      drive(5'h0D, 8'h05, 8'h05);
      tick();
      check("sub0.result", 32'(bus.result), 32'h00);
      check("sub0.zero", 32'(bus.zero), 32'd1);
      check("sub0.carry", 32'(bus.carry), 32'd0);
      drive(5'h0D, 8'h06, 8'h05);
      #1;
      check("sub1.in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      check("sub1.valid", 32'(bus.out_valid), 32'd1);
      check("sub1.result", 32'(bus.result), 32'hFF);
      check("sub1.carry", 32'(bus.carry), 32'd1);
      check("sub1.zero", 32'(bus.zero), 32'd0);
      tick();

      // Assorted single-cycle opcodes
      run_op("shl1", 5'h02, 8'h81, 8'h00, 8'h02, 1'b1);
      run_op("shr1", 5'h04, 8'h03, 8'h00, 8'h01, 1'b1);
      run_op("shr1b", 5'h05, 8'h00, 8'h02, 8'h01, 1'b0);
      run_op("pass1", 5'h01, 8'h11, 8'hA5, 8'hA5, 1'b0);
      run_op("and", 5'h06, 8'hF0, 8'h3C, 8'h30, 1'b0);
      run_op("or", 5'h09, 8'hF0, 8'h0C, 8'hFC, 1'b0);
      run_op("xor", 5'h0A, 8'hF0, 8'h3C, 8'hCC, 1'b0);
      run_op("orred", 5'h0B, 8'h40, 8'h00, 8'h01, 1'b0);
      run_op("xorred", 5'h0C, 8'h07, 8'h00, 8'h01, 1'b0);
      run_op("shl", 5'h11, 8'h0F, 8'h0C, 8'hF0, 1'b0);
      run_op("shr", 5'h12, 8'h80, 8'h03, 8'h10, 1'b0);
      run_op("rol0", 5'h13, 8'h96, 8'h08, 8'h96, 1'b0);

      // MUL 13 x 11: result appears exactly 8 edges after accept
      drive(5'h10, 8'd13, 8'd11);
      tick();
      bus.in_valid = 1'b0;
      bus.input0   = 8'hFF;
      bus.input1   = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("mul.busy_valid%0d", i), 32'(bus.out_valid), 32'd0);
         check($sformatf("mul.busy_ready%0d", i), 32'(bus.in_ready), 32'd0);
         tick();
      end
      check("mul.valid", 32'(bus.out_valid), 32'd1);
      check("mul.result", 32'(bus.result), 32'h8F);
      check("mul.carry", 32'(bus.carry), 32'd0);
      check("mul.zero", 32'(bus.zero), 32'd0);
      tick();

      // MUL 16 x 16: low byte zero, high byte nonzero
      drive(5'h10, 8'd16, 8'd16);
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("mul16.valid", 32'(bus.out_valid), 32'd1);
      check("mul16.result", 32'(bus.result), 32'h00);
      check("mul16.zero", 32'(bus.zero), 32'd1);
      check("mul16.carry", 32'(bus.carry), 32'd1);
      tick();

      // ROL under backpressure, then same-edge handoff to a pending ADD
      bus.out_ready = 1'b0;
      drive(5'h13, 8'h81, 8'h01);
      tick();
      drive(5'h0E, 8'h01, 8'h01);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bp.valid%0d", i), 32'(bus.out_valid), 32'd1);
         check($sformatf("bp.result%0d", i), 32'(bus.result), 32'h03);
         check($sformatf("bp.in_ready%0d", i), 32'(bus.in_ready), 32'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp.release_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      check("bp.next_valid", 32'(bus.out_valid), 32'd1);
      check("bp.next_result", 32'(bus.result), 32'h02);
      tick();

      // Flush on the 4th edge of a MUL: result never becomes valid
      drive(5'h10, 8'd3, 8'd3);
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      tick();
      flush = 1'b1;
      #1;
      check("flush.in_ready_low", 32'(bus.in_ready), 32'd0);
      tick();
      flush = 1'b0;
      #1;
      check("flush.in_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("flush.valid%0d", i), 32'(bus.out_valid), 32'd0);
         tick();
      end
      check("flush.result_kept", 32'(bus.result), 32'h02);

      // Flush together with a request: nothing is accepted
      flush = 1'b1;
      drive(5'h00, 8'h77, 8'h00);
      tick();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      check("flush_req.valid", 32'(bus.out_valid), 32'd0);
      check("flush_req.result", 32'(bus.result), 32'h02);

      // Illegal opcode, then a legal op clears err
      drive(5'h15, 8'hFF, 8'h01);
      tick();
      check("ill.valid", 32'(bus.out_valid), 32'd1);
      check("ill.result", 32'(bus.result), 32'h00);
      check("ill.err", 32'(bus.err), 32'd1);
      check("ill.zero", 32'(bus.zero), 32'd1);
      check("ill.carry", 32'(bus.carry), 32'd0);
      drive(5'h00, 8'h5A, 8'h00);
      tick();
      bus.in_valid = 1'b0;
      check("legal.err", 32'(bus.err), 32'd0);
      check("legal.result", 32'(bus.result), 32'h5A);
      tick();

      // Illegal again so reset has a set err to clear, then reset mid-MUL
      drive(5'h1F, 8'h00, 8'h00);
      tick();
      drive(5'h10, 8'd13, 8'd11);
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rst2.valid", 32'(bus.out_valid), 32'd0);
      check("rst2.result", 32'(bus.result), 32'h00);
      check("rst2.zero", 32'(bus.zero), 32'd0);
      check("rst2.carry", 32'(bus.carry), 32'd0);
      check("rst2.err", 32'(bus.err), 32'd0);
      check("rst2.in_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("rst2.valid%0d", i), 32'(bus.out_valid), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU in the NanoMIPS datapath.
- Keeps the 16 existing 4-bit operations as opcodes 5'h00–5'h0F.
- Adds variable-amount shifts/rotate and an iterative multi-cycle multiply.
- Sits between register-read and write-back, with valid/ready handshakes and carry/zero/error flags.

Parameters:
- WIDTH, 8, operand/result width in bits; must be at least 4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount field width; derived, not overridden.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous abort of any in-flight or held operation.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted this cycle when in_valid && in_ready.
- alu_opcode  in  5  operation select.
- input0  in  WIDTH  operand 0 (RS/SUPER).
- input1  in  WIDTH  operand 1 (RT/RX).
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result when out_valid && out_ready.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- carry  out  1  carry/borrow/overflow, per op.
- err  out  1  illegal opcode flag.

Behaviour:
- Reset (rst_n=0 at edge):
  - state=IDLE; out_valid=0; result=0; zero=0; carry=0; err=0; multiply counter=0.
  - Reset overrides flush and handshakes, including mid-multiply.
- States:
  - IDLE: no request in flight.
  - BUSY: multiply in progress.
  - DONE: result held.
- in_ready = !flush && (state==IDLE || (state==DONE && out_ready)). This allows back-to-back issue with no bubble.
- Operand capture: opcode and operands are captured on the accept edge; later input changes are ignored.
- Single-cycle ops (all except MUL):
  - On accept, result and flags are registered and state goes to DONE.
  - out_valid=1 in the cycle after accept (latency 1).
- Opcodes 5'h00–5'h0F:
  - 00 pass input0; 01 pass input1.
  - 02 input0<<1; 03 input1<<1.
  - 04 input0>>1 (logical); 05 input1>>1 (logical).
  - 06/07 AND; 08/09 OR; 0A XOR.
  - 0B {0,|input0}; 0C {0,^input0}.
  - 0D input1-input0; 0E/0F input0+input1.
  - All results are WIDTH bits, truncated.
- New opcodes:
  - 10 MUL: low WIDTH bits of input0*input1, unsigned.
  - 11 SHL: input0 << input1[SHW-1:0].
  - 12 SHR: input0 >> input1[SHW-1:0] (logical).
  - 13 ROL: input0 rotated left by input1[SHW-1:0].
  - 14–1F illegal: result=0, err=1, zero=1, carry=0, latency 1.
- carry:
  - ADD: carry-out.
  - SUB: borrow, i.e. input1 < input0 unsigned.
  - 02/03: bit shifted out of MSB; 04/05: bit shifted out of LSB.
  - MUL: 1 if the high WIDTH bits of the full product are nonzero.
  - All other ops: 0.
  - Shift amount 0 gives result=input0, carry=0.
- zero is computed from the registered result for every op. err=0 for every legal op.
- MUL sequencing:
  - Accept moves state IDLE/DONE to BUSY with counter=0.
  - Each BUSY edge performs one shift-add step (LSB-first on input1) and increments the counter.
  - The edge where counter==WIDTH-1 moves to DONE.
  - out_valid rises exactly WIDTH cycles after the accept edge. in_ready=0 throughout BUSY.
- DONE hold:
  - result and all flags stay stable while out_valid && !out_ready.
  - On out_ready without a new accept, state goes to IDLE and out_valid=0.
  - On out_ready with a new accept, the new op starts in the same edge.
- flush=1 at an edge (rst_n=1):
  - state=IDLE; out_valid=0; result and flags keep their last values; any in-flight MUL is discarded.
  - flush and in_valid together: no accept, because in_ready is forced 0.

Decomposition:
- Package alu_seq_pkg holds:
  - typedef enum logic[4:0] alu_op_t with all named opcodes (OP_PASS0 … OP_ROL).
  - typedef enum logic[1:0] alu_state_t {IDLE, BUSY, DONE}.
  - function is_multicycle(alu_op_t).
- One sub-module, alu_mul_iter (WIDTH):
  - Iterative shift-add multiplier with start/step/done signals and a 2*WIDTH-bit accumulator.
  - Single-cycle ops are computed combinationally inside alu_seq.

Test Plan (WIDTH=8):
- ADD 0xF0+0x20, out_ready=1 → cycle after accept: out_valid=1, result=0x10, carry=1, zero=0, err=0.
- SUB (0D) input0=5, input1=5 → result=0x00, zero=1, carry=0; then input0=6, input1=5 → result=0xFF, carry=1.
- MUL 13×11 → out_valid exactly 8 cycles after accept, result=0x8F, carry=0; MUL 16×16 → result=0x00, zero=1, carry=1; in_ready=0 throughout BUSY.
- Backpressure: ROL 0x81 by 1 with out_ready=0 for 3 cycles → result=0x03 held stable and in_ready=0; then out_ready=1 with a new ADD 1+1 pending → accepted the same cycle, next result=0x02.
- Flush at cycle 4 of a MUL → out_valid never asserts for it, in_ready=1 the next cycle; repeat with rst_n=0 mid-MUL → all outputs return to reset values.
- Illegal opcode 5'h15 → result=0, err=1, zero=1, latency 1; the following legal op clears err.
